// File: rtl/mult_arbiter.sv
// Shares one sequential signed multiplier among NUM_REQ requesters.
// Requests are latched per requester and served one at a time in round-robin order.
module mult_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int A_W     = 24,
  parameter int B_W     = 16,
  parameter int P_W     = 40
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_REQ-1:0]     req_start_i,
  input  logic [NUM_REQ*A_W-1:0] req_a_i,
  input  logic [NUM_REQ*B_W-1:0] req_b_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic [P_W-1:0]         req_prod_o,
  output logic                   mult_start_o,
  output logic [A_W-1:0]         mult_a_o,
  output logic [B_W-1:0]         mult_b_o,
  input  logic                   mult_ready_i,
  input  logic [P_W-1:0]         mult_prod_i,
  output logic                   busy_o,
  output logic                   err_o
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] pending_q;
  logic [A_W-1:0]     lat_a_q [NUM_REQ];
  logic [B_W-1:0]     lat_b_q [NUM_REQ];
  logic [GW-1:0]      grant_q, last_grant_q, arb_idx;
  logic               arb_found;
  logic [P_W-1:0]     prod_q;
  logic               err_q;
  logic               in_flight;

  // Only ISSUE and WAIT count as in flight; a start during DONE is a fresh request.
  assign in_flight = (state_q == ISSUE) || (state_q == WAIT);

  always_comb begin
    int idx;
    idx       = 0;
    arb_idx   = '0;
    arb_found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(last_grant_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!arb_found && pending_q[GW'(idx)]) begin
        arb_found = 1'b1;
        arb_idx   = GW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_found) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (mult_ready_i) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mult_start_o = 1'b0;
    mult_a_o     = '0;
    mult_b_o     = '0;
    req_ready_o  = '0;
    if (state_q == ISSUE) begin
      mult_start_o = 1'b1;
      mult_a_o     = lat_a_q[grant_q];
      mult_b_o     = lat_b_q[grant_q];
    end
    if (state_q == DONE) req_ready_o[grant_q] = 1'b1;
  end

  assign busy_o     = (state_q != IDLE);
  assign err_o      = err_q;
  assign req_prod_o = prod_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_REQ - 1);
      prod_q       <= '0;
      err_q        <= 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
        lat_a_q[k] <= '0;
        lat_b_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (req_start_i[k]) begin
          if (in_flight && (grant_q == GW'(k))) begin
            err_q <= 1'b1;
          end else begin
            lat_a_q[k]   <= req_a_i[k*A_W +: A_W];
            lat_b_q[k]   <= req_b_i[k*B_W +: B_W];
            pending_q[k] <= 1'b1;
          end
        end
      end
      // The granted requester cannot set its pending bit in ISSUE, so this clear never races a new start.
      if (state_q == ISSUE) pending_q[grant_q] <= 1'b0;
      if ((state_q == IDLE) && arb_found) begin
        grant_q      <= arb_idx;
        last_grant_q <= arb_idx;
      end
      if ((state_q == WAIT) && mult_ready_i) prod_q <= mult_prod_i;
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a behavioural 4-cycle multiplier model.
// Expected values are hand-computed constants.
module tb_mult_arbiter;

  localparam int MULT_LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_start_i;
  logic [71:0] req_a_i;
  logic [47:0] req_b_i;
  logic [2:0]  req_ready_o;
  logic [39:0] req_prod_o;
  logic        mult_start_o;
  logic [23:0] mult_a_o;
  logic [15:0] mult_b_o;
  logic        mult_ready_i;
  logic [39:0] mult_prod_i;
  logic        busy_o;
  logic        err_o;

  logic        model_on, model_ready, manual_ready;
  logic [39:0] model_prod, manual_prod;
  logic signed [39:0] pend_p;
  int          cnt;
  int          cyc = 0;
  int          start_cyc;
  int          compared = 0;
  int          mismatched = 0;

  typedef struct { int cyc; logic [23:0] a; logic [15:0] b; } start_ev_t;
  typedef struct { int cyc; logic [2:0] vec; logic [39:0] prod; } ready_ev_t;
  start_ev_t start_log[$];
  ready_ev_t ready_log[$];

  always #5 clk = ~clk;

  mult_arbiter #(.NUM_REQ(3), .A_W(24), .B_W(16), .P_W(40)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_start_i(req_start_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
    .req_ready_o(req_ready_o), .req_prod_o(req_prod_o),
    .mult_start_o(mult_start_o), .mult_a_o(mult_a_o), .mult_b_o(mult_b_o),
    .mult_ready_i(mult_ready_i), .mult_prod_i(mult_prod_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  assign mult_ready_i = model_ready | manual_ready;
  assign mult_prod_i  = manual_ready ? manual_prod : model_prod;

  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: ready pulse MULT_LAT cycles after the start cycle; garbage product otherwise.
  always @(negedge clk) begin
    model_ready = 1'b0;
    model_prod  = 40'hDEADBEEF00;
    if (!rst_n || !model_on) begin
      cnt = 0;
    end else begin
      if (cnt > 0) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          model_ready = 1'b1;
          model_prod  = pend_p;
        end
      end
      if (mult_start_o) begin
        cnt    = MULT_LAT;
        pend_p = 40'($signed(mult_a_o)) * 40'($signed(mult_b_o));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (mult_start_o) start_log.push_back('{cyc, mult_a_o, mult_b_o});
      if (req_ready_o != 3'b000) ready_log.push_back('{cyc, req_ready_o, req_prod_o});
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic setOps(input int k, input logic [23:0] a, input logic [15:0] b);
    req_a_i[k*24 +: 24] = a;
    req_b_i[k*16 +: 16] = b;
  endtask

  task automatic applyStimulus(input logic [2:0] mask);
    @(negedge clk);
    req_start_i = mask;
    start_cyc   = cyc;
    @(negedge clk);
    req_start_i = 3'b000;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    req_start_i = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
    start_log.delete();
    ready_log.delete();
  endtask

  initial begin
    rst_n        = 1'b0;
    req_start_i  = 3'b000;
    req_a_i      = '0;
    req_b_i      = '0;
    model_on     = 1'b1;
    manual_ready = 1'b0;
    manual_prod  = '0;
    waitCycles(2);
    checkOutput("rst_busy",   64'(busy_o), 64'd0);
    checkOutput("rst_ready",  64'(req_ready_o), 64'd0);
    checkOutput("rst_prod",   64'(req_prod_o), 64'd0);
    checkOutput("rst_mstart", 64'(mult_start_o), 64'd0);
    checkOutput("rst_ma",     64'(mult_a_o), 64'd0);
    checkOutput("rst_mb",     64'(mult_b_o), 64'd0);
    checkOutput("rst_err",    64'(err_o), 64'd0);
    rst_n = 1'b1;

    $display("[TB] single request");
    setOps(1, 24'h000400, 16'h2000);
    applyStimulus(3'b010);
    waitCycles(20);
    checkOutput("t1_nstart", 64'(start_log.size()), 64'd1);
    checkOutput("t1_nready", 64'(ready_log.size()), 64'd1);
    if (start_log.size() > 0 && ready_log.size() > 0) begin
      checkOutput("t1_lat_start", 64'(start_log[0].cyc - start_cyc), 64'd2);
      checkOutput("t1_ma", 64'(start_log[0].a), 64'h000400);
      checkOutput("t1_mb", 64'(start_log[0].b), 64'h2000);
      checkOutput("t1_lat_ready", 64'(ready_log[0].cyc - start_log[0].cyc), 64'd5);
      checkOutput("t1_vec", 64'(ready_log[0].vec), 64'b010);
      checkOutput("t1_prod", 64'(ready_log[0].prod), 64'h0000800000);
    end
    checkOutput("t1_prod_hold", 64'(req_prod_o), 64'h0000800000);
    checkOutput("t1_busy", 64'(busy_o), 64'd0);

    $display("[TB] simultaneous starts");
    doReset();
    setOps(0, 24'h000003, 16'h0005);
    setOps(1, 24'hFFFFFF, 16'h0007);
    setOps(2, 24'h001000, 16'h0100);
    applyStimulus(3'b111);
    waitCycles(30);
    checkOutput("t2_nready", 64'(ready_log.size()), 64'd3);
    if (ready_log.size() == 3) begin
      checkOutput("t2_vec0", 64'(ready_log[0].vec), 64'b001);
      checkOutput("t2_prod0", 64'(ready_log[0].prod), 64'h000000000F);
      checkOutput("t2_vec1", 64'(ready_log[1].vec), 64'b010);
      checkOutput("t2_prod1", 64'(ready_log[1].prod), 64'hFFFFFFFFF9);
      checkOutput("t2_vec2", 64'(ready_log[2].vec), 64'b100);
      checkOutput("t2_prod2", 64'(ready_log[2].prod), 64'h0000100000);
      checkOutput("t2_gap", 64'(ready_log[1].cyc - ready_log[0].cyc), 64'd7);
    end
    checkOutput("t2_busy", 64'(busy_o), 64'd0);

    $display("[TB] fairness");
    doReset();
    applyStimulus(3'b111);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      req_start_i = req_ready_o[0] ? 3'b001 : 3'b000;
    end
    req_start_i = 3'b000;
    waitCycles(20);
    checkOutput("t3_nready_min", 64'(ready_log.size() >= 4), 64'd1);
    if (ready_log.size() >= 4) begin
      checkOutput("t3_ord0", 64'(ready_log[0].vec), 64'b001);
      checkOutput("t3_ord1", 64'(ready_log[1].vec), 64'b010);
      checkOutput("t3_ord2", 64'(ready_log[2].vec), 64'b100);
      checkOutput("t3_ord3", 64'(ready_log[3].vec), 64'b001);
    end

    $display("[TB] protocol error");
    doReset();
    setOps(2, 24'h000010, 16'h0010);
    applyStimulus(3'b100);
    @(negedge clk);
    checkOutput("t4_err_before", 64'(err_o), 64'd0);
    setOps(2, 24'h7FFFFF, 16'h7FFF);
    applyStimulus(3'b100);
    checkOutput("t4_err_rise", 64'(err_o), 64'd1);
    waitCycles(20);
    checkOutput("t4_err_sticky", 64'(err_o), 64'd1);
    checkOutput("t4_nstart", 64'(start_log.size()), 64'd1);
    checkOutput("t4_nready", 64'(ready_log.size()), 64'd1);
    if (ready_log.size() > 0) begin
      checkOutput("t4_vec", 64'(ready_log[0].vec), 64'b100);
      checkOutput("t4_prod", 64'(ready_log[0].prod), 64'h0000000100);
    end

    $display("[TB] reset mid-WAIT");
    doReset();
    setOps(0, 24'h000002, 16'h0003);
    setOps(1, 24'h000004, 16'h0005);
    applyStimulus(3'b011);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t5_busy_wait", 64'(busy_o), 64'd1);
    model_on = 1'b0;
    rst_n    = 1'b0;
    #1;
    checkOutput("t5_busy", 64'(busy_o), 64'd0);
    checkOutput("t5_mstart", 64'(mult_start_o), 64'd0);
    checkOutput("t5_ma", 64'(mult_a_o), 64'd0);
    checkOutput("t5_ready", 64'(req_ready_o), 64'd0);
    checkOutput("t5_prod", 64'(req_prod_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_log.delete();
    ready_log.delete();
    @(negedge clk);
    manual_prod  = 40'h0000000123;
    manual_ready = 1'b1;
    @(negedge clk);
    manual_ready = 1'b0;
    waitCycles(20);
    checkOutput("t5_nready", 64'(ready_log.size()), 64'd0);
    checkOutput("t5_nstart", 64'(start_log.size()), 64'd0);
    checkOutput("t5_prod_after", 64'(req_prod_o), 64'd0);
    checkOutput("t5_busy_after", 64'(busy_o), 64'd0);
    model_on = 1'b1;

    $display("[TB] signed pass-through");
    doReset();
    setOps(0, 24'h800000, 16'h8000);
    applyStimulus(3'b001);
    waitCycles(15);
    checkOutput("t6_nstart", 64'(start_log.size()), 64'd1);
    if (start_log.size() > 0) begin
      checkOutput("t6_ma", 64'(start_log[0].a), 64'h800000);
      checkOutput("t6_mb", 64'(start_log[0].b), 64'h8000);
    end
    checkOutput("t6_prod", 64'(req_prod_o), 64'h4000000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
